// File: rtl/chunk_serial_adder_pkg.sv
// Shared types and elaboration helpers for the chunk-serial adder/subtractor.
// Helpers are evaluated on parameters only, so they fold to constants.
package chunk_serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } adder_state_t;

    // True when the slicing is legal: CHUNK in [1, WIDTH] and dividing WIDTH exactly.
    function automatic bit chunk_cfg_ok(input int width, input int chunk);
        return (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
    endfunction

    function automatic int slice_count(input int width, input int chunk);
        return (chunk >= 1) ? (width / chunk) : 1;
    endfunction

    function automatic int cnt_width(input int nchunk);
        return $clog2(nchunk) + 1;
    endfunction

    function automatic int idx_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/chunk_serial_adder_if.sv
// Request/result bundle of the chunk-serial adder. The master issues operands
// and start; the slave (the adder) returns busy/done and the registered result.
interface chunk_serial_adder_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;

    modport master (
        output start, sub, a, b, c,
        input  busy, done, s, cout, ovf
    );

    modport slave (
        input  start, sub, a, b, c,
        output busy, done, s, cout, ovf
    );

endinterface

// File: rtl/chunk_serial_adder_fa_chunk.sv
// Combinational ripple of CHUNK full-adder cells. Also exposes the carry into
// the top cell so the caller can form signed overflow on the final slice.
module chunk_serial_adder_fa_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             ci,
    output logic [CHUNK-1:0] sum,
    output logic             co,
    output logic             c_msb
);

    always_comb begin : ripple
        logic carry;
        // NOTE: blocking assignments are deliberate here: each cell must see the
        // carry produced by the previous cell within the same evaluation, and
        // every output gets a default first so no latch is inferred.
        carry = ci;
        c_msb = ci;
        sum   = '0;
        for (int i = 0; i < CHUNK; i++) begin
            c_msb  = carry;
            sum[i] = x[i] ^ y[i] ^ carry;
            carry  = (x[i] & y[i]) | (carry & (x[i] ^ y[i]));
        end
        co = carry;
    end

endmodule

// File: rtl/chunk_serial_adder.sv
// Multi-cycle adder/subtractor: one CHUNK-bit slice per cycle, LSB slice first,
// with the inter-slice carry held in a register. Start/busy/done handshake.
module chunk_serial_adder
    import chunk_serial_adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    chunk_serial_adder_if.slave   bus
);

    localparam int NCHUNK = slice_count(WIDTH, CHUNK);
    localparam int CNT_W  = cnt_width(NCHUNK);
    localparam int IDX_W  = idx_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NCHUNK - 1);

    generate
        if (!chunk_cfg_ok(WIDTH, CHUNK)) begin : g_cfg_err
            $error("chunk_serial_adder: WIDTH must be a multiple of CHUNK with 1 <= CHUNK <= WIDTH");
        end
    endgenerate

    adder_state_t     state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] s_q;
    logic             carry_q;
    logic             busy_q;
    logic             done_q;
    logic             cout_q;
    logic             ovf_q;

    logic [IDX_W-1:0] base;
    logic [CHUNK-1:0] a_slice;
    logic [CHUNK-1:0] b_slice;
    logic [CHUNK-1:0] sum_slice;
    logic             slice_co;
    logic             slice_c_msb;
    logic             last;

    // Bit offset of the slice being added this cycle.
    assign base    = IDX_W'(int'(cnt) * CHUNK);
    assign a_slice = a_q[base +: CHUNK];
    assign b_slice = b_q[base +: CHUNK];
    assign last    = (cnt == LAST_IDX);

    chunk_serial_adder_fa_chunk #(
        .CHUNK (CHUNK)
    ) u_fa_chunk (
        .x     (a_slice),
        .y     (b_slice),
        .ci    (carry_q),
        .sum   (sum_slice),
        .co    (slice_co),
        .c_msb (slice_c_msb)
    );

    // NOTE: all state updates are non-blocking so every register samples the
    // pre-edge values; operand registers are plain flops and are reset along
    // with the rest so nothing stale leaks out after an aborted operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        // Subtract is a + ~b + 1; the caller's carry-in is dropped.
                        a_q     <= bus.a;
                        b_q     <= bus.sub ? ~bus.b : bus.b;
                        carry_q <= bus.sub ? 1'b1 : bus.c;
                        cnt     <= '0;
                        busy_q  <= 1'b1;
                        state   <= ST_RUN;
                    end
                end

                ST_RUN: begin
                    s_q[base +: CHUNK] <= sum_slice;
                    carry_q            <= slice_co;
                    cnt                <= cnt + CNT_W'(1);
                    if (last) begin
                        cout_q <= slice_co;
                        ovf_q  <= slice_c_msb ^ slice_co;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    done_q <= 1'b0;
                    state  <= ST_IDLE;
                end

                default: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.s    = s_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_chunk_serial_adder.sv
// Directed bench for chunk_serial_adder: four instances (CHUNK 8/4/32 at WIDTH 32,
// and a 1-bit instance) share one stimulus set; sel picks which one sees start.
module tb_chunk_serial_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        sub;
    logic        c;
    logic [31:0] a;
    logic [31:0] b;
    int          sel;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    chunk_serial_adder_if #(.WIDTH(32)) bus8  ();
    chunk_serial_adder_if #(.WIDTH(32)) bus4  ();
    chunk_serial_adder_if #(.WIDTH(32)) bus32 ();
    chunk_serial_adder_if #(.WIDTH(1))  bus1  ();

    chunk_serial_adder #(.WIDTH(32), .CHUNK(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
    chunk_serial_adder #(.WIDTH(32), .CHUNK(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(bus4));
    chunk_serial_adder #(.WIDTH(32), .CHUNK(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));
    chunk_serial_adder #(.WIDTH(1),  .CHUNK(1))  dut1  (.clk(clk), .rst_n(rst_n), .bus(bus1));

    assign bus8.start  = start && (sel == 0);
    assign bus8.sub    = sub;
    assign bus8.a      = a;
    assign bus8.b      = b;
    assign bus8.c      = c;
    assign bus4.start  = start && (sel == 1);
    assign bus4.sub    = sub;
    assign bus4.a      = a;
    assign bus4.b      = b;
    assign bus4.c      = c;
    assign bus32.start = start && (sel == 2);
    assign bus32.sub   = sub;
    assign bus32.a     = a;
    assign bus32.b     = b;
    assign bus32.c     = c;
    assign bus1.start  = start && (sel == 3);
    assign bus1.sub    = sub;
    assign bus1.a      = a[0];
    assign bus1.b      = b[0];
    assign bus1.c      = c;

    logic        busy_m;
    logic        done_m;
    logic        cout_m;
    logic        ovf_m;
    logic [31:0] s_m;

    always_comb begin
        busy_m = bus8.busy;
        done_m = bus8.done;
        cout_m = bus8.cout;
        ovf_m  = bus8.ovf;
        s_m    = bus8.s;
        case (sel)
            1: begin
                busy_m = bus4.busy; done_m = bus4.done; cout_m = bus4.cout;
                ovf_m  = bus4.ovf;  s_m    = bus4.s;
            end
            2: begin
                busy_m = bus32.busy; done_m = bus32.done; cout_m = bus32.cout;
                ovf_m  = bus32.ovf;  s_m    = bus32.s;
            end
            3: begin
                busy_m = bus1.busy; done_m = bus1.done; cout_m = bus1.cout;
                ovf_m  = bus1.ovf;  s_m    = {31'b0, bus1.s};
            end
            default: ;
        endcase
    end

    function automatic int nchunk_of(input int k);
        case (k)
            0:       return 4;
            1:       return 8;
            default: return 1;
        endcase
    endfunction

    // Reference for 32-bit results, packed as {cout, ovf, s}; overflow uses the sign rule.
    function automatic logic [33:0] ref32(input logic [31:0] ra, input logic [31:0] rb,
                                          input logic rc, input logic rsub);
        logic [31:0] bb;
        logic [32:0] sum;
        logic        ov;
        bb  = rsub ? ~rb : rb;
        sum = {1'b0, ra} + {1'b0, bb} + {32'b0, (rsub ? 1'b1 : rc)};
        ov  = (ra[31] == bb[31]) && (sum[31] != ra[31]);
        return {sum[32], ov, sum[31:0]};
    endfunction

    // One operation on the selected instance. lat counts edges from the start edge
    // (inclusive) up to the edge after which done is seen.
    task automatic run_op(input logic [31:0] oa, input logic [31:0] ob, input logic oc,
                          input logic osub, output int lat, output logic [33:0] res);
        @(negedge clk);
        a = oa; b = ob; c = oc; sub = osub; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        while (!done_m && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        res = {cout_m, ovf_m, s_m};
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; sub = 1'b0; c = 1'b0; a = '0; b = '0; sel = 0;
        repeat (2) @(negedge clk);
        n_vec++;
        if ({bus8.busy, bus8.done, bus8.cout, bus8.ovf, bus8.s} !== 36'h0) begin
            n_err++;
            $display("FAIL reset_w32: got %h want 0", {bus8.busy, bus8.done, bus8.cout, bus8.ovf, bus8.s});
        end
        n_vec++;
        if ({bus1.busy, bus1.done, bus1.cout, bus1.ovf, bus1.s} !== 5'h0) begin
            n_err++;
            $display("FAIL reset_w1: got %b want 0", {bus1.busy, bus1.done, bus1.cout, bus1.ovf, bus1.s});
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({busy_m, done_m, cout_m, ovf_m, s_m} !== 36'h0) begin
            n_err++;
            $display("FAIL idle_after_reset: got %h want 0", {busy_m, done_m, cout_m, ovf_m, s_m});
        end
    endtask

    // Fields: {a, b, c, sub, s, cout, ovf}
    task automatic test_add_sub();
        logic [99:0] tbl [10];
        logic [31:0] va, vb, vs;
        logic        vc, vsub, vco, vov;
        logic [33:0] res;
        int          lat;
        tbl[0] = {32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        tbl[1] = {32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        tbl[2] = {32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0, 32'h2222_2222, 1'b0, 1'b0};
        tbl[3] = {32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
        tbl[4] = {32'h0000_00FF, 32'h0000_0001, 1'b1, 1'b0, 32'h0000_0101, 1'b0, 1'b0};
        tbl[5] = {32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
        tbl[6] = {32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
        tbl[7] = {32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0002, 1'b1, 1'b0};
        tbl[8] = {32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
        tbl[9] = {32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 1'b1};
        sel = 0;
        for (int i = 0; i < 10; i++) begin
            {va, vb, vc, vsub, vs, vco, vov} = tbl[i];
            run_op(va, vb, vc, vsub, lat, res);
            n_vec++;
            if (res !== {vco, vov, vs}) begin
                n_err++;
                $display("FAIL addsub[%0d]: got cout/ovf/s=%h want %h", i, res, {vco, vov, vs});
            end
            n_vec++;
            if (lat != 5) begin
                n_err++;
                $display("FAIL addsub_latency[%0d]: got %0d edges want 5", i, lat);
            end
        end
    endtask

    task automatic test_one_bit();
        logic [33:0] res;
        logic        ba, bb, bc, maj;
        int          lat;
        sel = 3;
        for (int i = 0; i < 8; i++) begin
            {ba, bb, bc} = 3'(i);
            maj = (ba & bb) | (ba & bc) | (bb & bc);
            run_op({31'b0, ba}, {31'b0, bb}, bc, 1'b0, lat, res);
            n_vec++;
            if ({res[33], res[32], res[0]} !== {maj, bc ^ maj, ba ^ bb ^ bc}) begin
                n_err++;
                $display("FAIL one_bit[%0d]: got cout/ovf/s=%b want %b", i,
                         {res[33], res[32], res[0]}, {maj, bc ^ maj, ba ^ bb ^ bc});
            end
            n_vec++;
            if (lat != 2) begin
                n_err++;
                $display("FAIL one_bit_latency[%0d]: got %0d edges want 2", i, lat);
            end
        end
    endtask

    task automatic test_ignored_start();
        int          dones;
        logic [33:0] res;
        sel   = 0;
        dones = 0;
        res   = '0;
        @(negedge clk);
        a = 32'h1111_1111; b = 32'h2222_2222; c = 1'b0; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = '0; b = '0;
        @(negedge clk);
        a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; c = 1'b1; sub = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (done_m) begin
                dones++;
                res = {cout_m, ovf_m, s_m};
            end
        end
        n_vec++;
        if (res !== {1'b0, 1'b0, 32'h3333_3333}) begin
            n_err++;
            $display("FAIL ignored_start_result: got %h want %h", res, {2'b00, 32'h3333_3333});
        end
        n_vec++;
        if (dones != 1) begin
            n_err++;
            $display("FAIL ignored_start_done_count: got %0d want 1", dones);
        end
    endtask

    task automatic test_reset_midop();
        logic [33:0] res;
        int          lat;
        int          dones;
        sel = 0;
        run_op(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, lat, res);
        n_vec++;
        if (res !== {1'b1, 1'b1, 32'h7FFF_FFFF}) begin
            n_err++;
            $display("FAIL pre_reset_op: got %h want %h", res, {2'b11, 32'h7FFF_FFFF});
        end
        @(negedge clk);
        a = 32'h0101_0101; b = 32'h0202_0202; c = 1'b0; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        n_vec++;
        if (busy_m !== 1'b1) begin
            n_err++;
            $display("FAIL busy_in_run: got %b want 1", busy_m);
        end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({busy_m, done_m, cout_m, ovf_m, s_m} !== 36'h0) begin
            n_err++;
            $display("FAIL async_reset_midop: got %h want 0", {busy_m, done_m, cout_m, ovf_m, s_m});
        end
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done_m) dones++;
        end
        n_vec++;
        if (dones != 0) begin
            n_err++;
            $display("FAIL done_after_abort: got %0d pulses want 0", dones);
        end
        run_op(32'h0101_0101, 32'h0202_0202, 1'b0, 1'b0, lat, res);
        n_vec++;
        if (res !== {2'b00, 32'h0303_0303} || lat != 5) begin
            n_err++;
            $display("FAIL op_after_abort: got %h lat %0d want %h lat 5", res, lat, {2'b00, 32'h0303_0303});
        end
    endtask

    // start stays high throughout; new operands are presented in each DONE cycle.
    task automatic test_back_to_back(input int k, input int n);
        logic [33:0] exp;
        int          nck, cyc, last_cyc, waited;
        bit          ok;
        sel = k;
        nck = nchunk_of(k);
        @(negedge clk);
        a = $urandom; b = $urandom; c = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
        start    = 1'b1;
        exp      = ref32(a, b, c, sub);
        cyc      = 0;
        last_cyc = 0;
        ok       = 1'b1;
        for (int i = 0; i < n && ok; i++) begin
            waited = 0;
            do begin
                @(negedge clk);
                cyc++;
                waited++;
            end while (!done_m && waited < 40);
            n_vec++;
            if (!done_m) begin
                n_err++;
                ok = 1'b0;
                $display("FAIL b2b_timeout[sel%0d #%0d]: no done within 40 cycles", k, i);
            end else begin
                if ({cout_m, ovf_m, s_m} !== exp) begin
                    n_err++;
                    $display("FAIL b2b_result[sel%0d #%0d]: got %h want %h", k, i, {cout_m, ovf_m, s_m}, exp);
                end
                if (i > 0) begin
                    n_vec++;
                    if (cyc - last_cyc != nck + 2) begin
                        n_err++;
                        $display("FAIL b2b_spacing[sel%0d #%0d]: got %0d want %0d", k, i, cyc - last_cyc, nck + 2);
                    end
                end
                last_cyc = cyc;
                a = $urandom; b = $urandom; c = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
                exp = ref32(a, b, c, sub);
            end
        end
        start = 1'b0;
        repeat (nck + 3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_one_bit();
        test_ignored_start();
        test_reset_midop();
        test_back_to_back(0, 1000);
        test_back_to_back(1, 200);
        test_back_to_back(2, 200);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
